// File: rtl/xcore_ram_arb_if.sv
// ----------------------------------------------------------------------------
// xcore_ram_arb_if
//   One requester channel of the Xcore RAM arbiter: a request half
//   (valid/ready plus address, write flag, byte mask and write data) and a
//   buffered read-response half (valid/ready plus read data).
//
//   modport master : the requester (fetch unit, load/store unit, bench)
//   modport slave  : the arbiter side
//
//   req_valid  master->slave  request valid
//   req_ready  slave->master  request accepted this cycle (the grant)
//   req_addr   master->slave  word address
//   req_wen    master->slave  1 = write, 0 = read
//   req_wem    master->slave  byte write mask (ignored on reads)
//   req_wdata  master->slave  write data
//   rsp_valid  slave->master  read data available
//   rsp_ready  master->slave  requester consumes the response
//   rsp_rdata  slave->master  read data
// ----------------------------------------------------------------------------
interface xcore_ram_arb_if #(
    parameter int AW = 10,
    parameter int DW = 16,
    parameter int MW = 2
) ();
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_wen;
    logic [MW-1:0] req_wem;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wem, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wem, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/xcore_ram_arb.sv
// ----------------------------------------------------------------------------
// xcore_ram_arb
//   Two-port round-robin arbiter and sequencer in front of a single-port
//   Xcore simulation RAM with a one-cycle registered read. At most one
//   access is granted per cycle; each requester gets a one-entry buffered
//   read response with valid/ready backpressure.
//
//   clk       in   clock, all state updates on the rising edge
//   rst       in   asynchronous active-high reset
//   m0, m1    slave channels (see xcore_ram_arb_if)
//   ram_cs    out  RAM chip select (any grant)
//   ram_wen   out  RAM write enable
//   ram_wem   out  RAM byte mask
//   ram_addr  out  RAM word address
//   ram_din   out  RAM write data
//   ram_dout  in   RAM read data, valid the cycle after a read is selected
// ----------------------------------------------------------------------------
module xcore_ram_arb #(
    parameter int AW = 10,
    parameter int DW = 16,
    parameter int MW = 2
) (
    input  logic                clk,
    input  logic                rst,
    xcore_ram_arb_if.slave      m0,
    xcore_ram_arb_if.slave      m1,
    output logic                ram_cs,
    output logic                ram_wen,
    output logic [MW-1:0]       ram_wem,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       ram_dout
);

    // last_grant = 1 means master 1 won the most recent granted cycle
    logic          last_grant;
    logic          rd_inflight_0;
    logic          rd_inflight_1;
    logic          rsp_valid_0;
    logic          rsp_valid_1;
    logic [DW-1:0] rsp_rdata_0;
    logic [DW-1:0] rsp_rdata_1;

    logic          blocked_0;
    logic          blocked_1;
    logic          elig_0;
    logic          elig_1;
    logic          grant_0;
    logic          grant_1;

    // A read may only issue when the response buffer is guaranteed free by
    // the capture edge: nothing in flight and any held response is being
    // consumed this cycle. Writes produce no response and are never blocked.
    always_comb begin
        blocked_0 = rd_inflight_0 | (rsp_valid_0 & ~m0.rsp_ready);
        blocked_1 = rd_inflight_1 | (rsp_valid_1 & ~m1.rsp_ready);
        elig_0    = m0.req_valid & ~(~m0.req_wen & blocked_0);
        elig_1    = m1.req_valid & ~(~m1.req_wen & blocked_1);
        grant_0   = 1'b0;
        grant_1   = 1'b0;
        if (!rst) begin
            if (elig_0 && elig_1) begin
                // tie: the master not granted last time wins
                grant_0 = last_grant;
                grant_1 = ~last_grant;
            end else begin
                grant_0 = elig_0;
                grant_1 = elig_1;
            end
        end
    end

    // RAM port mux; the byte mask is only driven for writes
    always_comb begin
        ram_cs   = grant_0 | grant_1;
        ram_wen  = 1'b0;
        ram_wem  = '0;
        ram_addr = m0.req_addr;
        ram_din  = m0.req_wdata;
        if (grant_1) begin
            ram_wen  = m1.req_wen;
            ram_wem  = m1.req_wen ? m1.req_wem : '0;
            ram_addr = m1.req_addr;
            ram_din  = m1.req_wdata;
        end else if (grant_0) begin
            ram_wen  = m0.req_wen;
            ram_wem  = m0.req_wen ? m0.req_wem : '0;
            ram_addr = m0.req_addr;
            ram_din  = m0.req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant    <= 1'b1;
            rd_inflight_0 <= 1'b0;
            rd_inflight_1 <= 1'b0;
            rsp_valid_0   <= 1'b0;
            rsp_valid_1   <= 1'b0;
            rsp_rdata_0   <= '0;
            rsp_rdata_1   <= '0;
        end else begin
            if (grant_0 | grant_1) begin
                last_grant <= grant_1;
            end
            // in-flight marks the cycle in which ram_dout carries our data
            rd_inflight_0 <= grant_0 & ~m0.req_wen;
            rd_inflight_1 <= grant_1 & ~m1.req_wen;

            // a capture wins over a same-edge consume so a back-to-back
            // read is never lost
            if (rd_inflight_0) begin
                rsp_valid_0 <= 1'b1;
                rsp_rdata_0 <= ram_dout;
            end else if (rsp_valid_0 && m0.rsp_ready) begin
                rsp_valid_0 <= 1'b0;
            end

            if (rd_inflight_1) begin
                rsp_valid_1 <= 1'b1;
                rsp_rdata_1 <= ram_dout;
            end else if (rsp_valid_1 && m1.rsp_ready) begin
                rsp_valid_1 <= 1'b0;
            end
        end
    end

    assign m0.req_ready = grant_0;
    assign m1.req_ready = grant_1;
    assign m0.rsp_valid = rsp_valid_0;
    assign m1.rsp_valid = rsp_valid_1;
    assign m0.rsp_rdata = rsp_rdata_0;
    assign m1.rsp_rdata = rsp_rdata_1;

endmodule
